op_share_sched: RTL and testbench

//  Round-robin scheduler that shares one fixed-latency bitwise datapath (e.g. a & b) among N_REQ requesters.

---
 rtl/op_share_sched.sv | 113 +++++++++++
 tb/tb_op_share_sched.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/op_share_sched.sv
// Round-robin scheduler sharing one fixed-latency datapath among N_REQ requesters, one op in flight.
// Response valid LAT+1 cycles after accept; requests refused while busy, response held under backpressure.
module op_share_sched #(
    parameter int N_REQ = 4,
    parameter int DW    = 8,
    parameter int LAT   = 2,
    localparam int IW   = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [N_REQ*DW-1:0] req_a,
    input  logic [N_REQ*DW-1:0] req_b,
    output logic                dp_start,
    output logic [DW-1:0]       dp_a,
    output logic [DW-1:0]       dp_b,
    input  logic [DW-1:0]       dp_res,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IW-1:0]       rsp_id,
    output logic [DW-1:0]       rsp_data,
    output logic                busy
);
    localparam int CW = $clog2(LAT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] rr_ptr;
    logic [CW-1:0] cnt;
    logic          win_found;
    logic [IW-1:0] win_idx;
    int            idx;

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_found) state_nxt = WAIT;
            WAIT:    if (cnt == CW'(1)) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && win_found && !rst)
            req_ready[win_idx] = 1'b1;
        busy = (state != IDLE);
    end

    // rr_ptr only moves on a completed response, so a reset-aborted op never counts as served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            cnt       <= '0;
            dp_start  <= 1'b0;
            dp_a      <= '0;
            dp_b      <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            dp_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        dp_a     <= req_a[int'(win_idx)*DW +: DW];
                        dp_b     <= req_b[int'(win_idx)*DW +: DW];
                        rsp_id   <= win_idx;
                        cnt      <= CW'(LAT);
                        dp_start <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        rsp_data  <= dp_res;
                        rsp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rr_ptr    <= (rsp_id == IW'(N_REQ - 1)) ? '0 : rsp_id + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_op_share_sched.sv
// Bench for op_share_sched: directed vector table, reset abort, LAT=1 build and randomized round-robin model.
module tb_op_share_sched;
    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int LAT = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_a, req_b;
    logic            dp_start;
    logic [DW-1:0]   dp_a, dp_b, dp_res;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [1:0]      rsp_id;
    logic [DW-1:0]   rsp_data;
    logic            busy;
    logic [DW-1:0]   op_a [N];
    logic [DW-1:0]   op_b [N];

    logic [1:0]      s_req_valid = '0;
    logic [1:0]      s_req_ready;
    logic [2*DW-1:0] s_req_a = '0;
    logic [2*DW-1:0] s_req_b = '0;
    logic            s_dp_start;
    logic [DW-1:0]   s_dp_a, s_dp_b, s_dp_res;
    logic            s_rsp_valid;
    logic            s_rsp_ready = 1'b0;
    logic [0:0]      s_rsp_id;
    logic [DW-1:0]   s_rsp_data;
    logic            s_busy;

    int n_chk  = 0;
    int n_fail = 0;
    int model_rr = 0;
    int dpc;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_a[i*DW +: DW] = op_a[i];
            req_b[i*DW +: DW] = op_b[i];
        end
    end

    // Datapath model: correct result only in the single cycle the scheduler should sample it.
    always @(posedge clk or posedge rst) begin
        if (rst)                         dpc <= 0;
        else if (dp_start)               dpc <= 1;
        else if (dpc != 0 && dpc < LAT)  dpc <= dpc + 1;
        else                             dpc <= 0;
    end
    assign dp_res   = (dpc == LAT - 1) ? (dp_a & dp_b) : ~(dp_a & dp_b);
    assign s_dp_res = s_dp_start ? (s_dp_a & s_dp_b) : ~(s_dp_a & s_dp_b);

    op_share_sched #(.N_REQ(N), .DW(DW), .LAT(LAT)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .dp_start(dp_start), .dp_a(dp_a), .dp_b(dp_b),
        .dp_res(dp_res), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .busy(busy)
    );

    op_share_sched #(.N_REQ(2), .DW(DW), .LAT(1)) u_small (
        .clk(clk), .rst(rst), .req_valid(s_req_valid), .req_ready(s_req_ready),
        .req_a(s_req_a), .req_b(s_req_b), .dp_start(s_dp_start), .dp_a(s_dp_a), .dp_b(s_dp_b),
        .dp_res(s_dp_res), .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_id(s_rsp_id),
        .rsp_data(s_rsp_data), .busy(s_busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Entered and left at posedge+1 with the scheduler idle.
    task automatic run_op(input logic [3:0] rv, input int stall, input int exp_id, input logic [7:0] exp_data);
        logic [7:0] cap_a, cap_b;
        cap_a     = op_a[exp_id];
        cap_b     = op_b[exp_id];
        req_valid = rv;
        rsp_ready = 1'($urandom);
        @(negedge clk);
        chk("grant", 32'(req_ready), 32'(4'b0001 << exp_id));
        chk("idle_busy", 32'(busy), 0);
        chk("idle_rsp_valid", 32'(rsp_valid), 0);
        @(posedge clk); #1;
        op_a[exp_id] = 8'($urandom);
        op_b[exp_id] = 8'($urandom);
        for (int k = 1; k <= LAT; k++) begin
            req_valid = 4'($urandom);
            rsp_ready = 1'($urandom);
            @(negedge clk);
            chk("dp_start", 32'(dp_start), 32'(k == 1));
            chk("dp_a", 32'(dp_a), 32'(cap_a));
            chk("dp_b", 32'(dp_b), 32'(cap_b));
            chk("wait_ready", 32'(req_ready), 0);
            chk("wait_busy", 32'(busy), 1);
            chk("wait_rsp_valid", 32'(rsp_valid), 0);
            @(posedge clk); #1;
        end
        for (int s = 0; s <= stall; s++) begin
            req_valid = 4'($urandom);
            rsp_ready = (s == stall);
            @(negedge clk);
            chk("rsp_valid", 32'(rsp_valid), 1);
            chk("rsp_id", 32'(rsp_id), 32'(exp_id));
            chk("rsp_data", 32'(rsp_data), 32'(exp_data));
            chk("resp_ready", 32'(req_ready), 0);
            chk("resp_busy", 32'(busy), 1);
            @(posedge clk); #1;
        end
        op_a[exp_id] = cap_a;
        op_b[exp_id] = cap_b;
        req_valid    = '0;
        rsp_ready    = 1'b0;
        model_rr     = (exp_id + 1) % N;
    endtask

    typedef struct {
        logic [3:0] rv;
        int         stall;
        int         id;
        logic [7:0] data;
    } vec_t;

    vec_t       vecs [12];
    logic [3:0] pend;
    int         win;

    initial begin
        op_a = '{8'hF0, 8'h55, 8'h0F, 8'hCC};
        op_b = '{8'h3C, 8'hFF, 8'hA5, 8'h3F};
        vecs[0]  = '{4'b0001, 0, 0, 8'h30};
        vecs[1]  = '{4'b1111, 0, 1, 8'h55};
        vecs[2]  = '{4'b1111, 0, 2, 8'h05};
        vecs[3]  = '{4'b1111, 0, 3, 8'h0C};
        vecs[4]  = '{4'b1111, 0, 0, 8'h30};
        vecs[5]  = '{4'b1111, 0, 1, 8'h55};
        vecs[6]  = '{4'b0100, 0, 2, 8'h05};
        vecs[7]  = '{4'b0101, 0, 0, 8'h30};
        vecs[8]  = '{4'b0101, 0, 2, 8'h05};
        vecs[9]  = '{4'b1000, 5, 3, 8'h0C};
        vecs[10] = '{4'b0110, 0, 1, 8'h55};
        vecs[11] = '{4'b0011, 2, 0, 8'h30};

        // Reset state, with every requester asserting valid.
        #1 rst = 1'b1;
        req_valid = 4'hF;
        #2;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_dp_start", 32'(dp_start), 0);
        chk("rst_dp_a", 32'(dp_a), 0);
        chk("rst_dp_b", 32'(dp_b), 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        req_valid = '0;

        foreach (vecs[i]) run_op(vecs[i].rv, vecs[i].stall, vecs[i].id, vecs[i].data);

        // Abort an op in its first WAIT cycle; rr_ptr must fall back to 0, not advance past 1.
        req_valid = 4'hF;
        @(negedge clk);
        chk("abort_grant", 32'(req_ready), 32'h2);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("abort_dp_start", 32'(dp_start), 0);
        chk("abort_dp_a", 32'(dp_a), 0);
        chk("abort_dp_b", 32'(dp_b), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_rsp_valid", 32'(rsp_valid), 0);
        chk("abort_req_ready", 32'(req_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = '0;
        model_rr = 0;
        for (int c = 0; c < LAT + 2; c++) begin
            @(negedge clk);
            chk("abort_stale_valid", 32'(rsp_valid), 0);
            chk("abort_stale_data", 32'(rsp_data), 0);
            @(posedge clk); #1;
        end
        run_op(4'hF, 0, 0, 8'h30);

        // LAT=1, N_REQ=2 build.
        s_req_a = {8'hAA, 8'h12};
        s_req_b = {8'h0F, 8'h34};
        s_req_valid = 2'b10;
        s_rsp_ready = 1'b1;
        @(negedge clk);
        chk("s_grant", 32'(s_req_ready), 32'h2);
        @(posedge clk); #1;
        s_req_valid = 2'b00;
        @(negedge clk);
        chk("s_dp_start", 32'(s_dp_start), 1);
        chk("s_early_valid", 32'(s_rsp_valid), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("s_rsp_valid", 32'(s_rsp_valid), 1);
        chk("s_rsp_id", 32'(s_rsp_id), 1);
        chk("s_rsp_data", 32'(s_rsp_data), 32'h0A);
        @(posedge clk); #1;
        s_req_valid = 2'b11;
        @(negedge clk);
        chk("s_done_valid", 32'(s_rsp_valid), 0);
        chk("s_wrap_grant", 32'(s_req_ready), 32'h1);
        @(posedge clk); #1;
        s_req_valid = 2'b00;
        @(posedge clk); #1;
        @(negedge clk);
        chk("s_rsp_id2", 32'(s_rsp_id), 0);
        chk("s_rsp_data2", 32'(s_rsp_data), 32'h10);
        @(posedge clk); #1;
        s_rsp_ready = 1'b0;

        // Randomized traffic against a round-robin model of pending requesters.
        pend = '0;
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i] = 1'b1;
                    op_a[i] = 8'($urandom);
                    op_b[i] = 8'($urandom);
                end
            end
            if ($urandom_range(0, 7) == 0) begin
                req_valid = '0;
                @(negedge clk);
                chk("rand_idle_ready", 32'(req_ready), 0);
                chk("rand_idle_busy", 32'(busy), 0);
                @(posedge clk); #1;
            end else begin
                win = -1;
                for (int k = 0; k < N; k++)
                    if (win < 0 && pend[(model_rr + k) % N]) win = (model_rr + k) % N;
                if (win >= 0) begin
                    run_op(pend, $urandom_range(0, 3), win, op_a[win] & op_b[win]);
                    pend[win] = 1'b0;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
